// File: rtl/next186_sram_pkg.sv
// next186_sram_pkg: shared types and widths for the SRAM arbiter and its pad wrapper.
package next186_sram_pkg;
    localparam int DATA_W     = 8;
    localparam int ADDR_W_DEF = 21;
    typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: video/CPU arbiter for an async SRAM, one access per IDLE->SETUP->HOLD pass.
// Video has priority unless a waiting CPU has been passed over VID_MAX times in a row.
module sram_arbiter
    import next186_sram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int VID_MAX = 4
) (
    input  logic              clk_sram,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_n,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_din,
    output logic              busy
);
    localparam int SW = $clog2(VID_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(VID_MAX);

    state_t              r_state;
    state_t              w_next;
    logic [SW-1:0]       r_starve;
    logic [SW-1:0]       w_starve_nxt;
    logic                r_gnt_cpu;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dout;
    logic                r_drive;
    logic                r_we_n;
    logic                r_vid_ack;
    logic                r_cpu_ack;
    logic [DATA_W-1:0]   r_vid_rdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic                w_any;
    logic                w_cpu_win;
    logic                w_wr;

    always_comb begin
        w_any        = vid_req || cpu_req;
        w_cpu_win    = cpu_req && (!vid_req || r_starve == STARVE_MAX);
        w_wr         = w_cpu_win && cpu_we;
        // Counter only advances while a CPU is actually waiting behind video.
        w_starve_nxt = (!cpu_req || w_cpu_win) ? '0 :
                       (r_starve == STARVE_MAX) ? r_starve : r_starve + 1'b1;
        w_next       = (r_state == IDLE)  ? (w_any ? SETUP : IDLE) :
                       (r_state == SETUP) ? HOLD : IDLE;
    end

    always_ff @(posedge clk_sram) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_sram) begin
        if (reset) begin
            r_starve    <= '0;
            r_gnt_cpu   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_drive     <= 1'b0;
            r_we_n      <= 1'b1;
            r_vid_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_vid_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_starve <= w_starve_nxt;
                    if (w_any) begin
                        r_gnt_cpu <= w_cpu_win;
                        r_we      <= w_wr;
                        r_addr    <= w_cpu_win ? cpu_addr : vid_addr;
                        r_dout    <= w_wr ? cpu_wdata : r_dout;
                        r_drive   <= w_wr;
                        r_we_n    <= !w_wr;
                    end
                end
                SETUP: r_we_n <= 1'b1;
                HOLD: begin
                    // Address and data stay put through HOLD to give the write its hold time.
                    r_drive     <= 1'b0;
                    r_cpu_ack   <= r_gnt_cpu;
                    r_vid_ack   <= !r_gnt_cpu;
                    r_cpu_rdata <= (r_gnt_cpu && !r_we) ? sram_din : r_cpu_rdata;
                    r_vid_rdata <= r_gnt_cpu ? r_vid_rdata : sram_din;
                end
                default: r_we_n <= 1'b1;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign SRAM_ADDR  = r_addr;
    assign SRAM_WE_n  = r_we_n;
    assign sram_dout  = r_dout;
    assign sram_drive = r_drive;
    assign vid_ack    = r_vid_ack;
    assign cpu_ack    = r_cpu_ack;
    assign vid_rdata  = r_vid_rdata;
    assign cpu_rdata  = r_cpu_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench with an ack scoreboard and a small SRAM model.
module tb_sram_arbiter;
    localparam int AW = 21;

    logic          clk_sram = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [7:0]    vid_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_n;
    logic [7:0]    sram_dout;
    logic          sram_drive;
    logic [7:0]    sram_din;
    logic          busy;

    sram_arbiter #(.ADDR_W(AW), .VID_MAX(4)) dut (
        .clk_sram(clk_sram), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_n(SRAM_WE_n), .sram_dout(sram_dout),
        .sram_drive(sram_drive), .sram_din(sram_din), .busy(busy)
    );

    always #5 clk_sram = ~clk_sram;

    // SRAM model: unwritten locations return a fixed address-derived pattern.
    logic [7:0]    mem [0:4095];
    logic [4095:0] written;

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[11:4] ^ 8'h5C;
    endfunction

    always @(posedge clk_sram) begin
        if (reset)
            written <= '0;
        else if (!SRAM_WE_n) begin
            mem[SRAM_ADDR[11:0]]     <= sram_dout;
            written[SRAM_ADDR[11:0]] <= 1'b1;
        end
    end

    assign sram_din = sram_drive ? sram_dout :
                      written[SRAM_ADDR[11:0]] ? mem[SRAM_ADDR[11:0]] : pat(SRAM_ADDR);

    typedef struct {
        bit         cpu;
        logic [7:0] data;
        bit         chk;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int got_cpu = 0;
    int got_vid = 0;
    int vid_left = 0;
    int b2b_n = 0;
    int last_vid = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit c, input logic [7:0] d, input bit k);
        exp_t e;
        e.cpu = c;
        e.data = d;
        e.chk = k;
        q.push_back(e);
    endtask

    // Scoreboard and always-true properties, sampled on the falling edge.
    always @(negedge clk_sram) begin
        if (!reset) begin
            chk("acks_exclusive", {31'd0, vid_ack && cpu_ack}, 0);
            chk("drive_only_busy", {31'd0, sram_drive && !busy}, 0);
            chk("we_only_busy", {31'd0, !SRAM_WE_n && !busy}, 0);
            if (vid_ack || cpu_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", {30'd0, cpu_ack, vid_ack}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_owner", {31'd0, cpu_ack}, {31'd0, e.cpu});
                    if (e.chk)
                        chk(e.cpu ? "cpu_rdata" : "vid_rdata", e.cpu ? cpu_rdata : vid_rdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_sram);
        @(negedge clk_sram);
        #1;
        cyc++;
        if (cpu_ack) begin
            cpu_req = 1'b0;
            got_cpu++;
        end
        if (vid_ack) begin
            got_vid++;
            if (b2b_n > 0 && last_vid >= 0) begin
                b2b_n--;
                chk("vid_b2b", cyc - last_vid, 3);
            end
            last_vid = cyc;
            if (vid_left > 0) begin
                vid_left--;
                if (vid_left == 0) vid_req = 1'b0;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && q.size() != 0; i++) step();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int g0;
        step();
        step();
        chk("rst_we_n", SRAM_WE_n, 1);
        chk("rst_drive", sram_drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {vid_ack, cpu_ack}, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dout", sram_dout, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;

        // CPU write: WE_n low one cycle, drive two cycles, ack in third cycle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h12345; cpu_wdata = 8'hA5;
        push(1'b1, 8'h00, 1'b0);
        step();
        chk("wr_setup_busy", busy, 1);
        chk("wr_setup_we_n", SRAM_WE_n, 0);
        chk("wr_setup_drive", sram_drive, 1);
        chk("wr_setup_addr", SRAM_ADDR, 32'h12345);
        chk("wr_setup_dout", sram_dout, 8'hA5);
        step();
        chk("wr_hold_we_n", SRAM_WE_n, 1);
        chk("wr_hold_drive", sram_drive, 1);
        chk("wr_hold_addr", SRAM_ADDR, 32'h12345);
        chk("wr_hold_dout", sram_dout, 8'hA5);
        chk("wr_hold_ack", cpu_ack, 0);
        step();
        chk("wr_ack", cpu_ack, 1);
        chk("wr_ack_drive", sram_drive, 0);
        chk("wr_ack_busy", busy, 0);
        chk("wr_mem", mem[12'h345], 8'hA5);

        // CPU read-back of the same address.
        cpu_req = 1'b1; cpu_we = 1'b0;
        push(1'b1, 8'hA5, 1'b1);
        g0 = got_cpu;
        for (int i = 0; i < 8 && got_cpu == g0; i++) begin
            step();
            chk("rd_drive", sram_drive, 0);
        end
        chk("rd_ack_seen", got_cpu - g0, 1);
        chk("rd_data", cpu_rdata, 8'hA5);

        // Simultaneous first request: video first, then CPU.
        vid_req = 1'b1; vid_addr = 21'h00100; vid_left = 1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00200;
        push(1'b0, pat(21'h00100), 1'b1);
        push(1'b1, pat(21'h00200), 1'b1);
        drain(20);

        // Starvation: four video grants, one CPU, then video resumes.
        vid_req = 1'b1; vid_addr = 21'h00100; vid_left = 6; b2b_n = 3; last_vid = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00200;
        for (int i = 0; i < 4; i++) push(1'b0, pat(21'h00100), 1'b1);
        push(1'b1, pat(21'h00200), 1'b1);
        for (int i = 0; i < 2; i++) push(1'b0, pat(21'h00100), 1'b1);
        drain(40);
        chk("starve_b2b_done", b2b_n, 0);
        step();
        step();

        // Request dropped after grant still acks; one dropped before grant is ignored.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00200;
        push(1'b1, pat(21'h00200), 1'b1);
        g0 = got_cpu;
        step();
        cpu_req = 1'b0;
        vid_req = 1'b1; vid_addr = 21'h00100;
        step();
        vid_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("late_drop_ack", got_cpu - g0, 1);
        chk("early_drop_queue", q.size(), 0);

        // Reset during SETUP of a write: strobe and drive release, no ack.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00300; cpu_wdata = 8'h77;
        g0 = got_cpu;
        step();
        chk("mid_setup_we_n", SRAM_WE_n, 0);
        reset = 1'b1;
        cpu_req = 1'b0;
        step();
        chk("mid_rst_we_n", SRAM_WE_n, 1);
        chk("mid_rst_drive", sram_drive, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acks", {vid_ack, cpu_ack}, 0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_rst_no_ack", got_cpu - g0, 0);
        chk("mid_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
